coeffs_loader: RTL and testbench

COEFFS_LOADER -- requirements
Module: coeffs_loader

---
 rtl/coeffs_loader.sv | 90 +++++++++
 tb/tb_coeffs_loader.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/coeffs_loader.sv
`default_nettype none
// ============================================================================
// Module   : coeffs_loader
// Brief    : Streams NUM_COEFFS coefficient words into a coefficient bank and
//            pulses write_done so the shadow registers can be updated.
// Revision : 1.0 - initial release
// ============================================================================
module coeffs_loader #(
  parameter int NUM_COEFFS = 64,
  parameter int COEFF_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clk_enable,
  input  logic                      start,
  input  logic                      abort,
  input  logic                      in_valid,
  input  logic signed [COEFF_W-1:0] in_data,
  output logic                      in_ready,
  output logic [5:0]                write_address,
  output logic signed [COEFF_W-1:0] coeffs_out,
  output logic                      write_enable,
  output logic                      write_done,
  output logic                      busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  localparam logic [5:0] C_LAST = 6'(NUM_COEFFS - 1);

  state_t     r_state;
  state_t     w_next;
  logic [5:0] r_count;
  logic       w_xfer;
  logic       w_last;
  logic       w_begin;

  assign in_ready = (r_state == S_LOAD) && clk_enable && !abort;
  assign w_xfer   = in_valid && in_ready;
  assign w_last   = (r_count == C_LAST);
  // abort outranks start even in IDLE
  assign w_begin  = (r_state == S_IDLE) && start && !abort;
  assign busy     = (r_state != S_IDLE);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_begin) w_next = S_LOAD;
      S_LOAD: begin
        if (abort)                 w_next = S_IDLE;
        else if (w_xfer && w_last) w_next = S_FLUSH;
      end
      S_FLUSH: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)             r_state <= S_IDLE;
    else if (clk_enable) r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count       <= '0;
      write_address <= '0;
      coeffs_out    <= '0;
      write_enable  <= 1'b0;
      write_done    <= 1'b0;
    end else if (clk_enable) begin
      write_done <= (r_state == S_FLUSH) && !abort;
      if (w_xfer) begin
        coeffs_out    <= in_data;
        write_address <= r_count;
        write_enable  <= 1'b1;
        // counter saturates on the last word so it never passes NUM_COEFFS-1
        if (!w_last) r_count <= r_count + 6'd1;
      end else begin
        write_enable <= 1'b0;
      end
      if (w_begin) r_count <= '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_coeffs_loader.sv
`default_nettype none
// Testbench for coeffs_loader: table vectors, directed sequences and random
// stimulus against a session-level reference model (64- and 8-word builds).
module tb_coeffs_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, clk_enable, start, abort, in_valid;
  logic [15:0] in_data;

  logic        rdy_a, we_a, done_a, busy_a;
  logic [5:0]  addr_a;
  logic [15:0] data_a;
  logic        rdy_b, we_b, done_b, busy_b;
  logic [5:0]  addr_b;
  logic [15:0] data_b;

  coeffs_loader #(.NUM_COEFFS(64), .COEFF_W(16)) dut64 (
    .clk(clk), .rst(rst), .clk_enable(clk_enable), .start(start), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(rdy_a),
    .write_address(addr_a), .coeffs_out(data_a), .write_enable(we_a),
    .write_done(done_a), .busy(busy_a));

  coeffs_loader #(.NUM_COEFFS(8), .COEFF_W(16)) dut8 (
    .clk(clk), .rst(rst), .clk_enable(clk_enable), .start(start), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(rdy_b),
    .write_address(addr_b), .coeffs_out(data_b), .write_enable(we_b),
    .write_done(done_b), .busy(busy_b));

  int checks   = 0;
  int failures = 0;

  // Reference model: a session is either inactive or active with a count of
  // words already accepted; count == N means all words are in, done pending.
  int          ncoef [2] = '{64, 8};
  bit          m_active [2];
  int          m_cnt    [2];
  bit          m_we     [2];
  int          m_addr   [2];
  logic [15:0] m_data   [2];
  bit          m_done   [2];
  int          writes   [2];
  int          dones    [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_ready(input int k);
    return m_active[k] && (m_cnt[k] < ncoef[k]) && clk_enable && !abort;
  endfunction

  task automatic model_edge(input int k);
    bit done_next;
    done_next = 1'b0;
    if (rst) begin
      m_active[k] = 1'b0; m_cnt[k] = 0; m_we[k] = 1'b0;
      m_addr[k] = 0; m_data[k] = '0; m_done[k] = 1'b0;
    end else if (clk_enable) begin
      if (abort) begin
        m_active[k] = 1'b0;
        m_we[k]     = 1'b0;
      end else if (!m_active[k]) begin
        m_we[k] = 1'b0;
        if (start) begin
          m_active[k] = 1'b1;
          m_cnt[k]    = 0;
        end
      end else if (m_cnt[k] < ncoef[k]) begin
        if (in_valid) begin
          m_we[k]   = 1'b1;
          m_addr[k] = m_cnt[k];
          m_data[k] = in_data;
          m_cnt[k]  = m_cnt[k] + 1;
        end else begin
          m_we[k] = 1'b0;
        end
      end else begin
        m_we[k]     = 1'b0;
        done_next   = 1'b1;
        m_active[k] = 1'b0;
      end
      m_done[k] = done_next;
    end
  endtask

  task automatic cmp_outs(input int k, input logic we, input logic [5:0] addr,
                          input logic [15:0] data, input logic done, input logic bsy);
    string t;
    t = (k == 0) ? "n64" : "n8";
    chk({t, "_write_enable"}, 32'(we), 32'(m_we[k]));
    chk({t, "_write_address"}, 32'(addr), 32'(m_addr[k]));
    chk({t, "_coeffs_out"}, 32'(data), 32'(m_data[k]));
    chk({t, "_write_done"}, 32'(done), 32'(m_done[k]));
    chk({t, "_busy"}, 32'(bsy), 32'(m_active[k]));
    if (we && done) chk({t, "_we_done_overlap"}, 32'(1), 32'(0));
  endtask

  task automatic tick();
    bit ce_at_edge;
    #1;
    chk("n64_in_ready", 32'(rdy_a), 32'(m_ready(0)));
    chk("n8_in_ready",  32'(rdy_b), 32'(m_ready(1)));
    ce_at_edge = clk_enable && !rst;
    model_edge(0);
    model_edge(1);
    @(posedge clk);
    #1;
    cmp_outs(0, we_a, addr_a, data_a, done_a, busy_a);
    cmp_outs(1, we_b, addr_b, data_b, done_b, busy_b);
    if (ce_at_edge) begin
      writes[0] += int'(we_a); writes[1] += int'(we_b);
      dones[0]  += int'(done_a); dones[1] += int'(done_b);
    end
  endtask

  task automatic drive(input logic r, input logic ce, input logic st, input logic ab,
                       input logic v, input logic [15:0] d);
    rst = r; clk_enable = ce; start = st; abort = ab; in_valid = v; in_data = d;
  endtask

  task automatic clear_counts();
    writes = '{0, 0};
    dones  = '{0, 0};
  endtask

  typedef struct {
    logic rst, ce, st, ab, v;
    logic [15:0] d;
    logic we;
    logic [5:0] addr;
    logic [15:0] data;
    logic done, busy;
  } vec_t;

  vec_t tbl [10];

  initial begin
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 6'd0, 16'h0000, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 6'd0, 16'h0000, 1'b0, 1'b1};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h1111, 1'b1, 6'd0, 16'h1111, 1'b0, 1'b1};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h2222, 1'b1, 6'd0, 16'h1111, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h2222, 1'b0, 6'd0, 16'h1111, 1'b0, 1'b1};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h2222, 1'b1, 6'd1, 16'h2222, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h3333, 1'b0, 6'd1, 16'h2222, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 6'd1, 16'h2222, 1'b0, 1'b1};
    tbl[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h4444, 1'b1, 6'd0, 16'h4444, 1'b0, 1'b1};
    tbl[9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h5555, 1'b0, 6'd0, 16'h0000, 1'b0, 1'b0};

    drive(1, 0, 0, 0, 0, 16'h0);
    clear_counts();

    // table vectors, same expectations for both builds
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].rst, tbl[i].ce, tbl[i].st, tbl[i].ab, tbl[i].v, tbl[i].d);
      tick();
      chk("tbl_we",   32'(we_b),   32'(tbl[i].we));
      chk("tbl_addr", 32'(addr_b), 32'(tbl[i].addr));
      chk("tbl_data", 32'(data_b), 32'(tbl[i].data));
      chk("tbl_done", 32'(done_b), 32'(tbl[i].done));
      chk("tbl_busy", 32'(busy_b), 32'(tbl[i].busy));
      chk("tbl_we64", 32'(we_a),   32'(tbl[i].we));
    end

    // full back-to-back load of 64 words
    drive(0, 1, 0, 0, 0, 16'h0); tick();
    clear_counts();
    drive(0, 1, 1, 0, 0, 16'h0); tick();
    for (int i = 1; i <= 64; i++) begin
      drive(0, 1, 0, 0, 1, 16'(i)); tick();
      chk("full_addr", 32'(addr_a), 32'(i - 1));
      chk("full_data", 32'(data_a), 32'(i));
    end
    drive(0, 1, 0, 0, 0, 16'h0); tick();
    chk("full_done_pulse", 32'(done_a), 32'd1);
    tick();
    chk("full_writes", 32'(writes[0]), 32'd64);
    chk("full_dones",  32'(dones[0]),  32'd1);
    chk("full_busy_after", 32'(busy_a), 32'd0);

    // gappy source
    clear_counts();
    drive(0, 1, 1, 0, 0, 16'h0); tick();
    for (int i = 0; i < 128; i++) begin
      drive(0, 1, 0, 0, (i % 2) == 0, 16'(16'h0100 + i / 2)); tick();
    end
    drive(0, 1, 0, 0, 0, 16'h0); tick(); tick();
    chk("gappy_writes", 32'(writes[0]), 32'd64);
    chk("gappy_dones",  32'(dones[0]),  32'd1);

    // clk_enable low for 3 cycles right after a transfer
    clear_counts();
    drive(0, 1, 1, 0, 0, 16'h0); tick();
    drive(0, 1, 0, 0, 1, 16'hABCD); tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 1, 16'h5A5A); tick();
      chk("hold_we",   32'(we_a),   32'd1);
      chk("hold_addr", 32'(addr_a), 32'd0);
      chk("hold_data", 32'(data_a), 32'hABCD);
    end
    drive(0, 1, 0, 0, 0, 16'h0); tick();
    chk("hold_writes", 32'(writes[0]), 32'd1);
    drive(0, 1, 0, 1, 0, 16'h0); tick();

    // abort after 10 words with in_valid on the same cycle
    clear_counts();
    drive(0, 1, 1, 0, 0, 16'h0); tick();
    for (int i = 0; i < 10; i++) begin
      drive(0, 1, 0, 0, 1, 16'(16'h0200 + i)); tick();
    end
    drive(0, 1, 1, 1, 1, 16'h0EEE); tick();
    drive(0, 1, 0, 0, 0, 16'h0); tick(); tick();
    chk("abort_writes", 32'(writes[0]), 32'd10);
    chk("abort_dones",  32'(dones[0]),  32'd0);
    chk("abort_busy",   32'(busy_a),    32'd0);
    drive(0, 1, 1, 0, 0, 16'h0); tick();
    drive(0, 1, 0, 0, 1, 16'h0777); tick();
    chk("restart_addr", 32'(addr_a), 32'd0);
    drive(0, 1, 0, 1, 0, 16'h0); tick();

    // 8-word build, 0x8000 as last word, start pulsed while busy
    clear_counts();
    drive(0, 1, 1, 0, 0, 16'h0); tick();
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, (i == 3), 0, 1, (i == 7) ? 16'h8000 : 16'(16'h0300 + i)); tick();
    end
    chk("n8_last_addr", 32'(addr_b), 32'd7);
    chk("n8_last_data", 32'(data_b), 32'h8000);
    drive(0, 1, 0, 0, 0, 16'h0); tick();
    chk("n8_done", 32'(done_b), 32'd1);
    chk("n8_writes", 32'(writes[1]), 32'd8);
    drive(0, 1, 0, 1, 0, 16'h0); tick();

    // reset during FLUSH of the 8-word build
    clear_counts();
    drive(0, 1, 1, 0, 0, 16'h0); tick();
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, 0, 0, 1, 16'(16'h0400 + i)); tick();
    end
    drive(1, 1, 0, 0, 0, 16'h0); tick();
    chk("rstflush_we",   32'(we_b),   32'd0);
    chk("rstflush_busy", 32'(busy_b), 32'd0);
    chk("rstflush_addr", 32'(addr_b), 32'd0);
    drive(0, 1, 0, 0, 0, 16'h0); tick(); tick();
    chk("rstflush_dones", 32'(dones[1]), 32'd0);

    // random stimulus
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(199) == 0, $urandom_range(9) < 8, $urandom_range(9) == 0,
            $urandom_range(39) == 0, $urandom_range(9) < 6, 16'($urandom));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
